jk_excite_counter: RTL

JK_EXCITE_COUNTER -- requirements
Module: jk_excite_counter

---
 rtl/jk_excite_counter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/jk_excite_counter.sv
// ---------------------------------------------------------------------------
// jk_excite_counter
//
// Modulo-MODULUS up/down counter that drives an external bank of JK
// flip-flops. The module keeps a shadow copy of the count (q). It works out
// the next count and presents the toggle-minimal J/K excitation that moves
// the downstream bank from q to the next count. The bank's Q outputs come
// back on fb_q and are compared against the shadow every cycle. Any
// disagreement latches the sticky mismatch flag.
//
// Parameters
//   WIDTH    counter / excitation bus width
//   MODULUS  count range 0..MODULUS-1 (legal: 2..2**WIDTH)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        count enable
//   up        direction: 1 = increment, 0 = decrement
//   load      parallel load request
//   load_val  parallel load value
//   fb_q      Q outputs fed back from the downstream JK bank
//   q         registered count (shadow of the downstream bank)
//   j, k      J/K excitation, bit i drives downstream flop i
//   tc        terminal count for the current direction (combinational)
//   load_err  one-cycle pulse after a load with load_val >= MODULUS
//   mismatch  sticky flag, set when fb_q disagrees with q
// ---------------------------------------------------------------------------
module jk_excite_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] fb_q,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             load_err,
    output logic             mismatch
);

    // All count arithmetic is done one bit wider than the bus. This lets
    // MODULUS = 2**WIDTH be represented, and the range checks never wrap.
    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO_W = '0;
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

    logic [WIDTH:0] q_reg;
    logic [WIDTH:0] nq_w;
    logic [WIDTH:0] load_w;
    logic           load_legal;
    logic           q_in_range;
    logic           check_en_reg;
    logic           load_err_reg;
    logic           mismatch_reg;

    // Next-count selection: a legal load wins, then fault recovery, then a
    // rejected load (hold), then count, then hold.
    always_comb begin
        load_w     = {1'b0, load_val};
        load_legal = load && (load_w < MOD_W);
        q_in_range = (q_reg < MOD_W);
        nq_w       = q_reg;
        if (load_legal) begin
            nq_w = load_w;
        end else if (!q_in_range) begin
            // Only reachable through a fault. Steer back into the legal range.
            nq_w = ZERO_W;
        end else if (load) begin
            nq_w = q_reg;
        end else if (en) begin
            if (up) begin
                nq_w = (q_reg == MAX_W) ? ZERO_W : (q_reg + ONE_W);
            end else begin
                nq_w = (q_reg == ZERO_W) ? MAX_W : (q_reg - ONE_W);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg        <= '0;
            load_err_reg <= 1'b0;
            mismatch_reg <= 1'b0;
            check_en_reg <= 1'b0;
        end else begin
            q_reg        <= nq_w;
            load_err_reg <= load && !load_legal;
            // The first edge after release only arms the checker. The bank
            // and the shadow are both known to be 0 only from that point on.
            check_en_reg <= 1'b1;
            if (check_en_reg && (fb_q != q_reg[WIDTH-1:0])) begin
                mismatch_reg <= 1'b1;
            end
        end
    end

    // Toggle-minimal excitation: J = K = 1 toggles the flop, and 0/0 holds
    // it. This is gated by rst_n so the bank is left alone while it is
    // being cleared.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
            assign j[gi] = rst_n & (nq_w[gi] ^ q_reg[gi]);
            assign k[gi] = rst_n & (nq_w[gi] ^ q_reg[gi]);
        end
    endgenerate

    assign q        = q_reg[WIDTH-1:0];
    assign tc       = up ? (q_reg == MAX_W) : (q_reg == ZERO_W);
    assign load_err = load_err_reg;
    assign mismatch = mismatch_reg;

endmodule
